// File: rtl/modsub_pipe_pkg.sv
// Shared constants and stage payload types for the Kyber modular subtractor.
// Imported by both the pipeline top and the reusable correction core.
package modsub_pipe_pkg;

  localparam int KYBER_Q  = 3329;
  localparam int KYBER_DW = 12;
  localparam int KYBER_TW = 8;

  // Signed x - y with one guard bit; range is -(Q-1)..Q-1.
  typedef logic signed [KYBER_DW:0] diff_t;

  typedef struct packed {
    diff_t               d;
    logic [KYBER_TW-1:0] tag;
  } s1_payload_t;

  typedef struct packed {
    logic [KYBER_DW-1:0] c;
    logic [KYBER_TW-1:0] tag;
  } s2_payload_t;

  function automatic diff_t sub_ext(input logic [KYBER_DW-1:0] x,
                                    input logic [KYBER_DW-1:0] y);
    return diff_t'({1'b0, x}) - diff_t'({1'b0, y});
  endfunction

endpackage

// File: rtl/modsub_core.sv
// Conditional +Q correction of a signed difference into 0..Q-1.
// Purely combinational; shared with the butterfly datapath.
module modsub_core
  import modsub_pipe_pkg::*;
#(
  parameter int Q  = KYBER_Q,
  parameter int DW = KYBER_DW
) (
  input  logic [DW:0]   d_i,
  output logic [DW-1:0] r_o
);

  localparam logic [DW-1:0] QW = DW'(Q);

  // Adding Q modulo 2^DW is exact here because the corrected value is < Q < 2^DW.
  always_comb begin
    r_o = d_i[DW-1:0] + (d_i[DW] ? QW : '0);
  end

endmodule

// File: rtl/modsub_pipe.sv
// Two-stage valid/ready pipelined modular subtractor, C = (A - B) mod Q.
// Stage 1 holds the signed difference, stage 2 the corrected result.
module modsub_pipe
  import modsub_pipe_pkg::*;
#(
  parameter int Q  = KYBER_Q,
  parameter int DW = KYBER_DW,
  parameter int TW = KYBER_TW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_a,
  input  logic [DW-1:0] in_b,
  input  logic          in_swap,
  input  logic [TW-1:0] in_tag,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_c,
  output logic [TW-1:0] out_tag
);

  s1_payload_t   s1_q, s1_d;
  s2_payload_t   s2_q, s2_d;
  logic          s1_valid_q, s1_valid_d;
  logic          s2_valid_q, s2_valid_d;
  logic          adv1, adv2;
  logic [DW-1:0] x, y;
  logic [DW-1:0] r;

  // Ready depends only on registered state, never on in_valid.
  assign adv2     = !s2_valid_q || out_ready;
  assign adv1     = !s1_valid_q || adv2;
  assign in_ready = adv1;

  modsub_core #(
    .Q  (Q),
    .DW (DW)
  ) u_core (
    .d_i (s1_q.d),
    .r_o (r)
  );

  always_comb begin
    x          = in_swap ? in_b : in_a;
    y          = in_swap ? in_a : in_b;
    s1_valid_d = s1_valid_q;
    s1_d       = s1_q;
    s2_valid_d = s2_valid_q;
    s2_d       = s2_q;

    if (adv2) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_d = '{c: r, tag: s1_q.tag};
      end
    end

    if (adv1) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_d = '{d: sub_ext(x, y), tag: in_tag};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_q       <= '0;
      s2_q       <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_c     = s2_q.c;
  assign out_tag   = s2_q.tag;

endmodule

// File: tb/tb_modsub_pipe.sv
// Self-checking bench for modsub_pipe: directed vector table, hand-written
// backpressure/reset sequences and a randomized run against a queue model.
module tb_modsub_pipe;

  localparam int Q = 3329;

  logic        clk       = 1'b0;
  logic        reset     = 1'b1;
  logic        in_valid  = 1'b0;
  logic        in_swap   = 1'b0;
  logic        out_ready = 1'b0;
  logic [11:0] in_a      = '0;
  logic [11:0] in_b      = '0;
  logic [7:0]  in_tag    = '0;
  logic        in_ready;
  logic        out_valid;
  logic [11:0] out_c;
  logic [7:0]  out_tag;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct { int c; int tag; int cyc; } res_t;
  typedef struct { int a; int b; bit swap; int tag; int exp_c; } vec_t;

  res_t exp_q[$];
  res_t obs_q[$];
  vec_t vecs[9];
  vec_t bp[4];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  modsub_pipe dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_swap   (in_swap),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_c     (out_c),
    .out_tag   (out_tag)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int ref_sub(input int a, input int b, input bit swap);
    int x;
    int y;
    x = swap ? b : a;
    y = swap ? a : b;
    return (x - y + Q) % Q;
  endfunction

  // Scoreboard: transfers are decided by values that are stable from the
  // negedge up to the next rising edge.
  always @(negedge clk) begin
    res_t e;
    if (reset) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL sb_unexpected: got result %0d tag %0d, expected none", out_c, out_tag);
        end else begin
          e = exp_q.pop_front();
          check("sb_c", 32'(out_c), 32'(e.c));
          check("sb_tag", 32'(out_tag), 32'(e.tag));
        end
        obs_q.push_back('{c: int'(out_c), tag: int'(out_tag), cyc: cyc});
      end
      if (in_valid && in_ready) begin
        assert (in_a < 12'(Q) && in_b < 12'(Q)) else $error("operand out of range");
        exp_q.push_back('{c: ref_sub(int'(in_a), int'(in_b), in_swap), tag: int'(in_tag), cyc: 0});
      end
    end
  end

  task automatic drive(input vec_t v);
    in_a    = 12'(v.a);
    in_b    = 12'(v.b);
    in_swap = v.swap;
    in_tag  = 8'(v.tag);
  endtask

  task automatic step(output bit acc);
    @(negedge clk);
    acc = in_valid && in_ready && !reset;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit acc;
    int k;
    int n;
    int acc_n;
    int cyc_n;

    vecs[0] = '{10,   5,    1'b0, 8'h30, 5};
    vecs[1] = '{5,    10,   1'b0, 8'h31, 3324};
    vecs[2] = '{0,    0,    1'b0, 8'h32, 0};
    vecs[3] = '{0,    3328, 1'b0, 8'h33, 1};
    vecs[4] = '{3328, 0,    1'b0, 8'h34, 3328};
    vecs[5] = '{3328, 3328, 1'b0, 8'h35, 0};
    vecs[6] = '{1,    2,    1'b0, 8'h36, 3328};
    vecs[7] = '{5,    10,   1'b1, 8'h11, 5};
    vecs[8] = '{3328, 0,    1'b1, 8'h22, 1};

    bp[0] = '{100, 50,   1'b0, 8'hA0, 50};
    bp[1] = '{50,  100,  1'b0, 8'hA1, 3279};
    bp[2] = '{7,   3000, 1'b0, 8'hA2, 336};
    bp[3] = '{7,   3000, 1'b1, 8'hA3, 2993};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_c", 32'(out_c), 0);
    check("rst_out_tag", 32'(out_tag), 0);
    reset = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 1);

    // Two-cycle latency
    out_ready = 1'b1;
    drive('{10, 5, 1'b0, 8'h01, 5});
    in_valid = 1'b1;
    step(acc);
    check("lat_accept", 32'(acc), 1);
    in_valid = 1'b0;
    check("lat_s1_only", 32'(out_valid), 0);
    step(acc);
    check("lat_valid", 32'(out_valid), 1);
    check("lat_c", 32'(out_c), 5);
    step(acc);
    obs_q.delete();

    // Vector table, back to back
    for (int i = 0; i < 9; i++) begin
      drive(vecs[i]);
      in_valid = 1'b1;
      step(acc);
      check("vec_accept", 32'(acc), 1);
    end
    in_valid = 1'b0;
    n = 0;
    while (obs_q.size() < 9 && n < 20) begin
      step(acc);
      n++;
    end
    check("vec_count", 32'(obs_q.size()), 9);
    for (int i = 0; i < 9 && i < obs_q.size(); i++) begin
      check("vec_c", 32'(obs_q[i].c), 32'(vecs[i].exp_c));
      check("vec_tag", 32'(obs_q[i].tag), 32'(vecs[i].tag));
      if (i > 0) check("vec_one_per_cycle", 32'(obs_q[i].cyc - obs_q[i-1].cyc), 1);
    end

    // Backpressure
    obs_q.delete();
    out_ready = 1'b0;
    k = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(bp[k]);
      step(acc);
      if (acc) k++;
    end
    check("bp_accepted", 32'(k), 2);
    check("bp_in_ready_low", 32'(in_ready), 0);
    drive(bp[k]);
    repeat (3) begin
      step(acc);
      check("bp_no_accept", 32'(acc), 0);
      check("bp_hold_valid", 32'(out_valid), 1);
      check("bp_hold_c", 32'(out_c), 32'(bp[0].exp_c));
      check("bp_hold_tag", 32'(out_tag), 32'(bp[0].tag));
    end
    out_ready = 1'b1;
    n = 0;
    while (k < 4 && n < 20) begin
      drive(bp[k]);
      step(acc);
      if (acc) k++;
      n++;
    end
    in_valid = 1'b0;
    check("bp_all_sent", 32'(k), 4);
    n = 0;
    while (obs_q.size() < 4 && n < 20) begin
      step(acc);
      n++;
    end
    repeat (3) step(acc);
    check("bp_count", 32'(obs_q.size()), 4);
    for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
      check("bp_c", 32'(obs_q[i].c), 32'(bp[i].exp_c));
      check("bp_tag", 32'(obs_q[i].tag), 32'(bp[i].tag));
    end

    // Reset with two items in flight
    obs_q.delete();
    in_valid = 1'b1;
    drive('{20, 3, 1'b0, 8'h50, 17});
    step(acc);
    drive('{3, 20, 1'b0, 8'h51, 3312});
    step(acc);
    in_valid = 1'b0;
    check("mid_inflight", 32'(out_valid), 1);
    reset = 1'b1;
    step(acc);
    check("mid_rst_out_valid", 32'(out_valid), 0);
    check("mid_rst_out_c", 32'(out_c), 0);
    check("mid_rst_in_ready", 32'(in_ready), 1);
    reset = 1'b0;
    drive('{7, 9, 1'b0, 8'h77, 3327});
    in_valid = 1'b1;
    step(acc);
    check("mid_fresh_accept", 32'(acc), 1);
    in_valid = 1'b0;
    step(acc);
    check("mid_fresh_valid", 32'(out_valid), 1);
    check("mid_fresh_c", 32'(out_c), 3327);
    check("mid_fresh_tag", 32'(out_tag), 32'h77);
    step(acc);
    check("mid_discarded", 32'(obs_q.size()), 1);

    // Randomized traffic against the scoreboard
    obs_q.delete();
    acc_n = 0;
    cyc_n = 0;
    while (acc_n < 10000 && cyc_n < 60000) begin
      if (!in_valid && $urandom_range(0, 9) < 7) begin
        in_valid = 1'b1;
        in_a     = 12'($urandom_range(0, Q - 1));
        in_b     = 12'($urandom_range(0, Q - 1));
        in_swap  = 1'($urandom_range(0, 1));
        in_tag   = 8'($urandom_range(0, 255));
      end
      out_ready = ($urandom_range(0, 9) < 7);
      step(acc);
      cyc_n++;
      if (acc) begin
        acc_n++;
        in_valid = 1'b0;
      end
    end
    check("rand_sent", 32'(acc_n), 10000);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 20) begin
      step(acc);
      n++;
    end
    check("rand_drain", 32'(exp_q.size()), 0);
    check("rand_count", 32'(obs_q.size()), 32'(acc_n));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
